// File: rtl/sb_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : sb_tx_serializer_if
// Purpose  : Message handshake between the sideband encoder and the serializer.
// Revision : 1.0
// ============================================================================
interface sb_tx_serializer_if;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [63:0] msg_i;
    logic [63:0] data_i;
    logic [1:0]  data_len_i;

    modport master (
        output msg_valid_i, msg_i, data_i, data_len_i,
        input  msg_ready_o
    );

    modport slave (
        input  msg_valid_i, msg_i, data_i, data_len_i,
        output msg_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/sb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sb_tx_serializer
// Purpose  : Queues sideband header/payload messages and shifts them out
//            LSB-first on dataPin_o with a forwarded clkPin_o (2 cycles per UI).
// Revision : 1.0
// ============================================================================
module sb_tx_serializer #(
    parameter int QUEUE_DEPTH = 2,
    parameter int GAP_UI      = 32
) (
    input  wire logic           clk_800MHz,
    input  wire logic           reset,
    input  wire logic           enable_i,
    sb_tx_serializer_if.slave   bus,
    output logic                dataPin_o,
    output logic                clkPin_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int c_PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int c_GAP_W = $clog2(2 * GAP_UI + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(2 * GAP_UI - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    logic [63:0]        r_q_msg  [QUEUE_DEPTH];
    logic [63:0]        r_q_data [QUEUE_DEPTH];
    logic [1:0]         r_q_len  [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ready;

    state_t             r_state;
    logic [63:0]        r_shift;
    logic [63:0]        r_payload;
    logic               r_has_data;
    logic               r_in_data;
    logic [6:0]         r_k;
    logic [c_GAP_W-1:0] r_gap;

    logic               w_enq;
    logic               w_deq;
    logic               w_msg_end;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [1:0]         w_head_len;
    logic [63:0]        w_head_data;

    assign bus.msg_ready_o = r_ready;
    assign w_head_len      = r_q_len[r_rd_ptr];
    assign w_head_data     = r_q_data[r_rd_ptr];

    always_comb begin
        w_enq       = bus.msg_valid_i && r_ready;
        w_msg_end   = (r_state == ST_GAP) && (r_gap == c_GAP_LAST) &&
                      (r_in_data || !r_has_data);
        // A new message may start from IDLE or straight out of the final gap cycle.
        w_deq       = enable_i && (r_count != '0) &&
                      ((r_state == ST_IDLE) || w_msg_end);
        w_count_nxt = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
    end

    always_ff @(posedge clk_800MHz) begin
        if (w_enq) begin
            r_q_msg[r_wr_ptr]  <= bus.msg_i;
            r_q_data[r_wr_ptr] <= bus.data_i;
            r_q_len[r_wr_ptr]  <= bus.data_len_i;
        end
    end

    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_payload  <= '0;
            r_has_data <= 1'b0;
            r_in_data  <= 1'b0;
            r_k        <= '0;
            r_gap      <= '0;
            dataPin_o  <= 1'b0;
            clkPin_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count   <= w_count_nxt;
            r_ready   <= (w_count_nxt != c_CNT_FULL);
            dataPin_o <= 1'b0;
            clkPin_o  <= 1'b0;
            done_o    <= 1'b0;

            case (r_state)
                ST_HDR, ST_DATA: begin
                    // Clock high on the first half of each UI so the falling edge is mid-bit.
                    dataPin_o <= r_shift[r_k[6:1]];
                    clkPin_o  <= ~r_k[0];
                    r_k       <= r_k + 7'd1;
                    if (r_k == 7'd127) begin
                        r_state <= ST_GAP;
                        r_gap   <= '0;
                    end
                end
                ST_GAP: begin
                    r_gap <= r_gap + c_GAP_W'(1);
                    if (r_gap == c_GAP_LAST) begin
                        if (r_has_data && !r_in_data) begin
                            r_state   <= ST_DATA;
                            r_shift   <= r_payload;
                            r_in_data <= 1'b1;
                            r_k       <= '0;
                        end else begin
                            done_o  <= 1'b1;
                            r_state <= ST_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            if (w_deq) begin
                r_state    <= ST_HDR;
                busy_o     <= 1'b1;
                r_shift    <= r_q_msg[r_rd_ptr];
                r_has_data <= (w_head_len == 2'b01) || (w_head_len == 2'b10);
                r_payload  <= (w_head_len == 2'b01) ? {32'd0, w_head_data[31:0]}
                                                    : w_head_data;
                r_in_data  <= 1'b0;
                r_k        <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_tx_serializer
// Purpose  : Scoreboard bench: stimulus queues expected packets, a monitor
//            decodes dataPin_o on clkPin_o falling edges and compares.
// Revision : 1.0
// ============================================================================
module tb_sb_tx_serializer;
    logic clk_800MHz = 1'b0;
    logic reset      = 1'b0;
    logic enable_i   = 1'b0;
    logic dataPin_o, clkPin_o, busy_o, done_o;

    sb_tx_serializer_if bus ();

    sb_tx_serializer #(.QUEUE_DEPTH(2), .GAP_UI(32)) dut (
        .clk_800MHz (clk_800MHz),
        .reset      (reset),
        .enable_i   (enable_i),
        .bus        (bus.slave),
        .dataPin_o  (dataPin_o),
        .clkPin_o   (clkPin_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_800MHz = ~clk_800MHz;

    int cyc = 0;
    always @(posedge clk_800MHz) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_pkt_q[$];
    int          exp_npk_q[$];
    int          done_cyc_q[$];
    int          start_cyc_q[$];
    int          mon_bits = 0;
    int          pkts_since_done = 0;
    int          done_total = 0;
    logic        prev_clk = 1'b0;
    logic [63:0] shreg = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: rebuilds packets from falling edges of clkPin_o.
    always @(negedge clk_800MHz) begin
        if (!reset) begin
            mon_bits        = 0;
            prev_clk        = 1'b0;
            pkts_since_done = 0;
            exp_pkt_q.delete();
            exp_npk_q.delete();
        end else begin
            if (!prev_clk && clkPin_o && mon_bits == 0) start_cyc_q.push_back(cyc);
            if (prev_clk && !clkPin_o) begin
                shreg[mon_bits] = dataPin_o;
                mon_bits++;
                if (mon_bits == 64) begin
                    if (exp_pkt_q.size() == 0) check("unexpected_packet", shreg, 64'hx);
                    else check("packet", shreg, exp_pkt_q.pop_front());
                    pkts_since_done++;
                    mon_bits = 0;
                end
            end
            if (done_o) begin
                done_cyc_q.push_back(cyc);
                done_total++;
                if (exp_npk_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("done_packets", 64'(pkts_since_done), 64'(exp_npk_q.pop_front()));
                check("done_partial_bits", 64'(mon_bits), 64'd0);
                pkts_since_done = 0;
            end
            prev_clk = clkPin_o;
        end
    end

    task automatic send(input logic [63:0] m, input logic [63:0] d, input logic [1:0] l,
                        input int npk, input logic [63:0] pl, output int acc);
        int n = 0;
        exp_pkt_q.push_back(m);
        if (npk == 2) exp_pkt_q.push_back(pl);
        exp_npk_q.push_back(npk);
        bus.msg_valid_i = 1'b1;
        bus.msg_i       = m;
        bus.data_i      = d;
        bus.data_len_i  = l;
        while (!bus.msg_ready_o && n < 3000) begin
            @(posedge clk_800MHz); #1;
            n++;
        end
        check("enqueue_timeout", 64'(n >= 3000), 64'd0);
        @(posedge clk_800MHz); #1;
        acc = cyc;
        bus.msg_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_total < target && n < 4000) begin
            @(posedge clk_800MHz); #1;
            n++;
        end
        check("done_timeout", 64'(done_total), 64'(target));
    endtask

    task automatic wait_bits(input int nb, input logic need_clk);
        int n = 0;
        while (!(mon_bits == nb && (!need_clk || clkPin_o)) && n < 1000) begin
            @(posedge clk_800MHz); #1;
            n++;
        end
        check("bit_wait_timeout", 64'(n >= 1000), 64'd0);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    int acc, acc_dummy;

    initial begin
        bus.msg_valid_i = 1'b0;
        bus.msg_i       = '0;
        bus.data_i      = '0;
        bus.data_len_i  = '0;

        repeat (3) @(posedge clk_800MHz); #1;
        check("rst_dataPin", 64'(dataPin_o), 64'd0);
        check("rst_clkPin",  64'(clkPin_o),  64'd0);
        check("rst_busy",    64'(busy_o),    64'd0);
        check("rst_done",    64'(done_o),    64'd0);
        reset = 1'b1;
        @(posedge clk_800MHz); #1;
        check("rst_ready", 64'(bus.msg_ready_o), 64'd1);

        // Header only: latency and frame length
        enable_i = 1'b1;
        start_cyc_q.delete(); done_cyc_q.delete();
        send(64'hA5A5_0000_0000_0001, 64'h0, 2'b00, 1, 64'h0, acc);
        wait_done(1);
        check("t1_first_bit_cycle", 64'(start_cyc_q[0]), 64'(acc + 2));
        check("t1_done_cycle",      64'(done_cyc_q[0]),  64'(acc + 193));
        check("t1_busy_after_done", 64'(busy_o), 64'd0);

        // Reserved length behaves as header only
        send(64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1, 64'h0, acc);
        wait_done(2);

        // 32-bit payload: upper half forced to zero
        send(64'h0000_0000_0000_00C2, 64'hFFFF_FFFF_1234_5678, 2'b01, 2,
             64'h0000_0000_1234_5678, acc);
        wait_done(3);

        // Two 64-bit messages back to back
        start_cyc_q.delete(); done_cyc_q.delete();
        send(64'h1111_2222_3333_4444, 64'hCAFE_F00D_0BAD_BEEF, 2'b10, 2,
             64'hCAFE_F00D_0BAD_BEEF, acc);
        send(64'h8000_0000_0000_0003, 64'h0F0F_0F0F_F0F0_F0F0, 2'b10, 2,
             64'h0F0F_0F0F_F0F0_F0F0, acc);
        wait_done(5);
        check("t3_packet_starts",   64'(start_cyc_q.size()), 64'd4);
        check("t3_no_idle_between", 64'(start_cyc_q[2]), 64'(done_cyc_q[0] + 1));

        // Backpressure with transmit disabled
        enable_i = 1'b0;
        send(64'h0000_0000_0000_0AA1, 64'h0, 2'b00, 1, 64'h0, acc);
        send(64'h0000_0000_0000_0BB2, 64'h0000_0000_7654_3210, 2'b01, 2,
             64'h0000_0000_7654_3210, acc);
        check("t4_ready_full", 64'(bus.msg_ready_o), 64'd0);
        fork
            send(64'h0000_0000_0000_0CC3, 64'h0, 2'b00, 1, 64'h0, acc_dummy);
        join_none
        repeat (8) @(posedge clk_800MHz); #1;
        check("t4_idle_disabled", 64'(busy_o), 64'd0);
        check("t4_still_full",    64'(bus.msg_ready_o), 64'd0);
        enable_i = 1'b1;
        wait_done(8);

        // Enable dropped mid-header
        send(64'h0000_0000_0000_5A5A, 64'h9999_9999_DEAD_BEEF, 2'b01, 2,
             64'h0000_0000_DEAD_BEEF, acc);
        send(64'h0000_0000_0000_0077, 64'h0, 2'b00, 1, 64'h0, acc);
        wait_bits(20, 1'b0);
        enable_i = 1'b0;
        wait_done(9);
        repeat (20) @(posedge clk_800MHz); #1;
        check("t5_parked_idle",  64'(busy_o), 64'd0);
        check("t5_entry_held",   64'(exp_pkt_q.size()), 64'd1);
        check("t5_ready_spare",  64'(bus.msg_ready_o), 64'd1);
        enable_i = 1'b1;
        wait_done(10);

        // Asynchronous reset mid-header
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'b00, 1, 64'h0, acc);
        send(64'h5555_5555_5555_5555, 64'h0, 2'b00, 1, 64'h0, acc);
        wait_bits(35, 1'b1);
        check("t6_pre_dataPin", 64'(dataPin_o), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_async_dataPin", 64'(dataPin_o), 64'd0);
        check("t6_async_clkPin",  64'(clkPin_o),  64'd0);
        check("t6_async_busy",    64'(busy_o),    64'd0);
        repeat (3) @(posedge clk_800MHz); #1;
        reset = 1'b1;
        @(posedge clk_800MHz); #1;
        check("t6_ready_release", 64'(bus.msg_ready_o), 64'd1);
        repeat (20) @(posedge clk_800MHz); #1;
        check("t6_queue_empty", 64'(busy_o), 64'd0);
        send(64'h0000_0000_0000_8001, 64'h0, 2'b00, 1, 64'h0, acc);
        wait_done(11);
        check("end_no_pending", 64'(exp_pkt_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
